// File: rtl/led_demo_pkg.sv
// Shared definitions for the LED demo blocks: button FSM states and default
// timing constants for a 100 MHz system clock.
package led_demo_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        REPEAT
    } btn_state_e;

    localparam int unsigned CLK_HZ                  = 100_000_000;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 1_000_000;   // 10 ms
    localparam int unsigned DEFAULT_LONG_CYCLES     = 100_000_000; // 1 s
    localparam int unsigned DEFAULT_REPEAT_CYCLES   = 20_000_000;  // 200 ms

endpackage

// File: rtl/btn_sync.sv
// Two-flop synchroniser for an asynchronous board input; synchronous
// active-high reset clears both stages to 0.
module btn_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            q_o    <= 1'b0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// Push-button front end: synchronise, debounce, then turn the clean level into
// single-cycle press / release / long-press / auto-repeat strobes.
module button_conditioner
    import led_demo_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES,
    parameter int unsigned REPEAT_CYCLES   = DEFAULT_REPEAT_CYCLES,
    parameter int unsigned CNT_W           = 32
) (
    input  logic clk,
    input  logic rst,
    input  logic button_raw,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic repeat_pulse
);

    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);
    localparam logic [CNT_W-1:0] DbLast   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] RepLast  = CNT_W'(REPEAT_CYCLES - 1);

    logic             sync_btn;
    logic             accept;
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] hold_cnt;
    logic [CNT_W-1:0] rep_cnt;
    btn_state_e       state;

    btn_sync u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (button_raw),
        .q_o (sync_btn)
    );

    // A level change is accepted on the edge where the mismatch run hits DEBOUNCE_CYCLES.
    assign accept = (sync_btn != btn_level) && (db_cnt == DbLast);

    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt        <= '0;
            hold_cnt      <= '0;
            rep_cnt       <= '0;
            state         <= IDLE;
            btn_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            long_pulse    <= 1'b0;
            repeat_pulse  <= 1'b0;

            if (sync_btn == btn_level) begin
                db_cnt <= '0;
            end else if (accept) begin
                db_cnt    <= '0;
                btn_level <= ~btn_level;
            end else begin
                db_cnt <= db_cnt + CntOne;
            end

            // Accepted falls are tested first so a release beats a coincident terminal count.
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state       <= PRESSED;
                        press_pulse <= 1'b1;
                        hold_cnt    <= '0;
                    end
                end
                PRESSED: begin
                    if (accept) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                    end else if (hold_cnt == LongLast) begin
                        state      <= REPEAT;
                        long_pulse <= 1'b1;
                        rep_cnt    <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + CntOne;
                    end
                end
                REPEAT: begin
                    if (accept) begin
                        state         <= IDLE;
                        release_pulse <= 1'b1;
                    end else if (rep_cnt == RepLast) begin
                        repeat_pulse <= 1'b1;
                        rep_cnt      <= '0;
                    end else begin
                        rep_cnt <= rep_cnt + CntOne;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
